mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: begin an operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-005 SHALL have ports a and b, input, 32 each: a is the multiplicand or dividend, b is the multiplier or divisor; both captured on the start edge.
REQ-006 SHALL have port busy, output, 1: high from the cycle after start is accepted through the FIX cycle.
REQ-007 SHALL have port done, output, 1: one-cycle pulse when hi/lo are updated.
REQ-008 SHALL have ports hi and lo, output, 32 each: result registers. Product is {hi,lo}; for divides, quotient is lo and remainder is hi.
REQ-009 SHALL have ports alu_a and alu_b, output, 32 each: operands driven to the shared ALU.
REQ-010 SHALL have port alu_f, output, 4: ALU control; 4'b0010 is add, 4'b0110 is subtract.
REQ-011 SHALL have port alu_y, input, 32: ALU result, consumed in the same cycle.

Function
REQ-012 SHALL implement the FSM IDLE -> RUN -> FIX -> IDLE; RUN lasts exactly 32 cycles, counted by a 5-bit iteration counter; FIX lasts 1 cycle.
REQ-013 SHALL take IDLE->RUN when start=1 at a clock edge; the edge loads working regs: P_hi=0, P_lo=|b| (mult) or |a| (div), operand M=|a| (mult) or |b| (div), count=0.
REQ-014 SHALL ignore start while busy=1; start in FIX or RUN SHALL NOT queue.
REQ-015 SHALL perform multiply iterations (RUN) as follows: alu_a=P_hi, alu_b=M, alu_f=0010; carry c=(a31&b31)|((a31|b31)&~y31); if P_lo[0], {P_hi,P_lo}<={c,alu_y,P_lo[31:1]}, else shift {0,P_hi,P_lo} right by 1.
REQ-016 SHALL perform divide iterations (RUN) as follows: R'={P_hi[30:0],P_lo[31]}; alu_a=R', alu_b=M, alu_f=0110; no-borrow n=(a31&~b31)|((a31|~b31)&~y31); if P_hi[31]|n then P_hi<=alu_y, P_lo<={P_lo[30:0],1}, else P_hi<=R', P_lo<={P_lo[30:0],0}.
REQ-017 SHALL register results in FIX: hi<=P_hi, lo<=P_lo (sign-corrected per REQ-024); done=1 in the following cycle only.
REQ-018 SHALL assert done exactly 34 cycles after the edge that sampled start; busy SHALL be high for exactly 33 cycles.
REQ-019 SHALL hold hi and lo stable throughout RUN/FIX (the previous result) and change them only at the FIX edge or on reset.
REQ-020 SHALL drive, outside RUN: alu_a=0, alu_b=0, alu_f=4'b0010.
REQ-021 SHALL handle divide by zero with no special case: the result SHALL be lo=32'hFFFFFFFF and hi=dividend (unsigned path).
REQ-022 SHALL treat a start asserted in the same cycle as done as a new operation, accepted normally.

Reset
REQ-023 SHALL, on reset=1 at a clock edge (including mid-RUN/FIX), set state to IDLE and set hi=0, lo=0, busy=0, done=0, count=0, and all working regs to 0; the aborted operation SHALL produce no done.

Configuration
REQ-024 SHALL compile in signed ops when MDU_SIGNED_EN is defined. With it, op[1]=1 uses magnitudes per REQ-013, and FIX negates: the product when a31^b31; the quotient when a31^b31; the remainder when a31. -2^31/-1 SHALL give lo=32'h80000000, hi=0.
REQ-025 SHALL, when MDU_SIGNED_EN is undefined, ignore op[1] (10 behaves as 00, 11 as 01) and make FIX a plain copy.

Verification
REQ-026 SHALL verify: MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> done at +34 cycles, hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-027 SHALL verify: DIVU a=100, b=7 -> lo=14, hi=2; DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5.
REQ-028 SHALL verify with MDU_SIGNED_EN: MULT a=-3, b=5 -> {hi,lo}=64'hFFFFFFFF_FFFFFFF1; DIV a=-7, b=2 -> lo=-3, hi=-1.
REQ-029 SHALL verify: reset pulsed at RUN cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a subsequent start completes normally.
REQ-030 SHALL verify: start held high for 40 cycles -> exactly one op accepted, the second accepted on the done cycle; alu_f=0010 and operands 0 whenever idle.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: sequential 32x32 multiply / divide unit built around a shared external ALU.
//
// Operation: IDLE -> RUN (32 iterations) -> FIX (1 cycle) -> IDLE.
//   Multiply uses shift-and-add, with the multiplier held in P_lo.
//   Divide uses restoring shift-and-subtract, with the dividend held in P_lo.
//   Both run on operand magnitudes. FIX copies the working registers to hi/lo.
//
// Optional feature: define MDU_SIGNED_EN to enable signed MULT/DIV (op[1]=1).
//   FIX then applies sign correction to the result.
//   Without the macro, op[1] is ignored and FIX is a plain copy.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   start        begin an operation (sampled only in IDLE)
//   op[1:0]      00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   a, b         multiplicand/dividend, multiplier/divisor; captured on the start edge
//   busy         high from the cycle after start through the FIX cycle
//   done         one-cycle pulse once hi/lo hold the new result
//   hi, lo       result: product {hi,lo}; for divides, quotient in lo and remainder in hi
//   alu_a/alu_b  operands to the shared ALU
//   alu_f        ALU function: 4'b0010 add, 4'b0110 subtract
//   alu_y        ALU result, consumed combinationally in the same cycle
module mdu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_f,
    input  logic [31:0] alu_y
);

    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic [31:0] m_q, m_d;
    logic        is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic [31:0] abs_a, abs_b;
    logic [31:0] rem_shift;
    logic        carry, no_borrow;

`ifdef MDU_SIGNED_EN
    // Sign corrections to apply in FIX: negate the product or quotient,
    // and negate the remainder.
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] prod_neg;

    assign signed_op = op[1];
    assign prod_neg  = 64'd0 - {phi_q, plo_q};
`else
    logic        unused_op_sign;

    assign unused_op_sign = op[1];
    assign signed_op      = 1'b0;
`endif

    assign abs_a = (signed_op && a[31]) ? (32'd0 - a) : a;
    assign abs_b = (signed_op && b[31]) ? (32'd0 - b) : b;

    // Partial remainder shifted left, bringing in the next dividend bit.
    assign rem_shift = {phi_q[30:0], plo_q[31]};

    // Carry out of P_hi + M, reconstructed from the operand and result MSBs.
    assign carry = (phi_q[31] & m_q[31]) | ((phi_q[31] | m_q[31]) & ~alu_y[31]);

    // No borrow from R' - M, i.e. R' >= M as unsigned.
    assign no_borrow = (rem_shift[31] & ~m_q[31]) | ((rem_shift[31] | ~m_q[31]) & ~alu_y[31]);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        phi_d    = phi_q;
        plo_d    = plo_q;
        m_d      = m_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_f    = AluAdd;
`ifdef MDU_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    count_d  = 5'd0;
                    is_div_d = op[0];
                    phi_d    = 32'd0;
                    plo_d    = op[0] ? abs_a : abs_b;
                    m_d      = op[0] ? abs_b : abs_a;
`ifdef MDU_SIGNED_EN
                    neg_res_d = signed_op & (a[31] ^ b[31]);
                    neg_rem_d = signed_op & a[31];
`endif
                end
            end

            StRun: begin
                alu_b = m_q;
                if (is_div_q) begin
                    alu_a = rem_shift;
                    alu_f = AluSub;
                    // P_hi[31] means R' overflowed 32 bits and certainly exceeds M.
                    if (phi_q[31] | no_borrow) begin
                        phi_d = alu_y;
                        plo_d = {plo_q[30:0], 1'b1};
                    end else begin
                        phi_d = rem_shift;
                        plo_d = {plo_q[30:0], 1'b0};
                    end
                end else begin
                    alu_a = phi_q;
                    alu_f = AluAdd;
                    if (plo_q[0]) begin
                        {phi_d, plo_d} = {carry, alu_y, plo_q[31:1]};
                    end else begin
                        {phi_d, plo_d} = {1'b0, phi_q, plo_q[31:1]};
                    end
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = StFix;
                end
            end

            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
`ifdef MDU_SIGNED_EN
                if (is_div_q) begin
                    lo_d = neg_res_q ? (32'd0 - plo_q) : plo_q;
                    hi_d = neg_rem_q ? (32'd0 - phi_q) : phi_q;
                end else if (neg_res_q) begin
                    {hi_d, lo_d} = prod_neg;
                end else begin
                    hi_d = phi_q;
                    lo_d = plo_q;
                end
`else
                hi_d = phi_q;
                lo_d = plo_q;
`endif
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= 5'd0;
            phi_q    <= 32'd0;
            plo_q    <= 32'd0;
            m_q      <= 32'd0;
            is_div_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
`ifdef MDU_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            phi_q    <= phi_d;
            plo_q    <= plo_d;
            m_q      <= m_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MDU_SIGNED_EN
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq.
// Models the shared ALU. Runs a vector table plus random operations through an
// expected-result queue, and adds hand sequences for the mid-RUN reset and the
// held start.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_f;
    logic [31:0] alu_y;

    int passed = 0;
    int total  = 0;

    logic [63:0] exp_q[$];

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;    // {hi, lo}
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign alu_y = (alu_f == 4'b0110) ? (alu_a - alu_b) : (alu_a + alu_b);

    mdu_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .alu_a (alu_a),
        .alu_b (alu_b),
        .alu_f (alu_f),
        .alu_y (alu_y)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference result from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic        sgn;
        logic [31:0] mx, my, q, r;
        logic [63:0] p;
`ifdef MDU_SIGNED_EN
        sgn = o[1];
`else
        sgn = 1'b0;
`endif
        mx = (sgn && x[31]) ? (32'd0 - x) : x;
        my = (sgn && y[31]) ? (32'd0 - y) : y;
        if (!o[0]) begin
            p = {32'd0, mx} * {32'd0, my};
            if (sgn && (x[31] ^ y[31])) p = 64'd0 - p;
            return p;
        end
        if (my == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = mx;
        end else begin
            q = mx / my;
            r = mx % my;
        end
        if (sgn && (x[31] ^ y[31])) q = 32'd0 - q;
        if (sgn && x[31]) r = 32'd0 - r;
        return {r, q};
    endfunction

    // Start one operation, then follow it to done and compare against the queue.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        logic [63:0] prev;
        logic [63:0] want;
        int          cyc;
        int          busy_cnt;
        bit          stable;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back(exp);
        prev = {hi, lo};
        @(posedge clk);
        #1;
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = busy ? 1 : 0;
        stable   = 1'b1;
        check({name, " run alu_f"}, {60'd0, alu_f}, o[0] ? 64'd6 : 64'd2);
        while (!done && cyc < 60) begin
            if ({hi, lo} !== prev) stable = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cnt++;
        end
        check({name, " done cycle"}, 64'(cyc), 64'd34);
        check({name, " busy cycles"}, 64'(busy_cnt), 64'd33);
        check({name, " hi/lo held"}, {63'd0, stable}, 64'd1);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        check({name, " result"}, {hi, lo}, want);
        check({name, " idle alu"}, {28'd0, alu_f, alu_a}, {28'd0, 4'b0010, 32'd0});
        check({name, " idle alu_b"}, {32'd0, alu_b}, 64'd0);
        @(posedge clk);
        #1;
        check({name, " done pulse width"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;

        // Directed table: operations with hand-known or arithmetic-derived results.
        vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001});
        vecs.push_back('{2'b01, 32'd100, 32'd7, {32'd2, 32'd14}});
        vecs.push_back('{2'b01, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}});
        vecs.push_back('{2'b00, 32'd3, 32'd5, 64'd15});
        vecs.push_back('{2'b00, 32'h12345678, 32'h9ABCDEF0, 64'h12345678 * 64'h9ABCDEF0});
        vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}});
        vecs.push_back('{2'b01, 32'h80000000, 32'd3, {32'h80000000 % 32'd3, 32'h80000000 / 32'd3}});
        vecs.push_back('{2'b01, 32'd7, 32'd100, {32'd7, 32'd0}});
        vecs.push_back('{2'b00, 32'd0, 32'hDEADBEEF, 64'd0});
`ifdef MDU_SIGNED_EN
        vecs.push_back('{2'b10, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1});
        vecs.push_back('{2'b11, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}});
        vecs.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}});
        vecs.push_back('{2'b11, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}});
        vecs.push_back('{2'b10, 32'hFFFFFFFC, 32'hFFFFFFFA, 64'd24});
`else
        vecs.push_back('{2'b10, 32'hFFFFFFFD, 32'd5, 64'h00000004_FFFFFFF1});
        vecs.push_back('{2'b11, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}});
        vecs.push_back('{2'b11, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0}});
        vecs.push_back('{2'b11, 32'd7, 32'hFFFFFFFE, {32'd7, 32'd0}});
        vecs.push_back('{2'b10, 32'hFFFFFFFC, 32'hFFFFFFFA, 64'hFFFFFFFC * 64'hFFFFFFFA});
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);
        check("reset alu", {28'd0, alu_f, alu_a}, {28'd0, 4'b0010, 32'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        for (int i = 0; i < 6; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 2) ? 32'd0 : ((i == 4) ? 32'(($urandom % 1000) + 1) : $urandom);
            run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb));
        end

        // Reset in RUN cycle 10: the aborted op clears everything and never reports done.
        begin
            int done_seen;
            @(negedge clk);
            start = 1'b1;
            op    = 2'b01;
            a     = 32'd100;
            b     = 32'd7;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (9) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("abort busy/done", {62'd0, busy, done}, 64'd0);
            check("abort hi/lo", {hi, lo}, 64'd0);
            done_seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                #1;
                if (done) done_seen++;
            end
            check("abort no done", 64'(done_seen), 64'd0);
            run_op("after abort", 2'b01, 32'd100, 32'd7, {32'd2, 32'd14});
        end

        // start held high for 40 cycles: one op accepted, the next on the done cycle.
        begin
            int   accepts;
            int   rise1;
            int   rise2;
            int   done_at;
            int   idle_bad;
            int   waited;
            logic busy_prev;
            logic [63:0] want;
            accepts  = 0;
            rise1    = 0;
            rise2    = 0;
            done_at  = 0;
            idle_bad = 0;
            busy_prev = busy;
            @(negedge clk);
            start = 1'b1;
            op    = 2'b00;
            a     = 32'd3;
            b     = 32'd5;
            exp_q.push_back(64'd15);
            exp_q.push_back(64'd15);
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk);
                #1;
                if (busy && !busy_prev) begin
                    accepts++;
                    if (accepts == 1) rise1 = i;
                    else if (accepts == 2) rise2 = i;
                end
                busy_prev = busy;
                if (!busy && (alu_f !== 4'b0010 || alu_a !== 32'd0 || alu_b !== 32'd0)) begin
                    idle_bad++;
                end
                if (done) begin
                    if (done_at == 0) done_at = i;
                    want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
                    check("hold first result", {hi, lo}, want);
                end
            end
            start = 1'b0;
            check("hold accepts", 64'(accepts), 64'd2);
            check("hold first accept", 64'(rise1), 64'd1);
            check("hold done cycle", 64'(done_at), 64'd34);
            check("hold second accept", 64'(rise2), 64'd35);
            check("hold idle alu", 64'(idle_bad), 64'd0);
            waited = 0;
            while (!done && waited < 60) begin
                @(posedge clk);
                #1;
                waited++;
            end
            check("hold second done", {63'd0, done}, 64'd1);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
            check("hold second result", {hi, lo}, want);
        end

        check("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
